// File: rtl/dilithium_pkg.sv
// Shared Dilithium arithmetic constants: modulus, coefficient/product widths
// and the Barrett constant used by the modular reducer.
package dilithium_pkg;

  localparam int COEFF_W = 23;
  localparam int PROD_W  = 46;
  localparam logic [COEFF_W-1:0] Q = 23'd8380417;

  // mu = floor(2^48 / q); with products below 2^46 the quotient estimate is
  // at most one short, so the reducer output stays below 2q.
  localparam int BARRETT_SHIFT = 48;
  localparam int MU_W          = 26;
  localparam logic [MU_W-1:0] BARRETT_MU = MU_W'((64'd1 << BARRETT_SHIFT) / 64'd8380417);

  function automatic logic coeff_in_range(input logic [COEFF_W-1:0] v);
    return v < Q;
  endfunction

endpackage

// File: rtl/dilithium_reduction.sv
// Combinational Barrett reducer: maps a 46-bit product to a value in [0, 2*m).
// The caller applies the final conditional subtraction.
module dilithium_reduction
  import dilithium_pkg::*;
(
  input  logic [PROD_W-1:0]  p_i,
  input  logic [COEFF_W-1:0] m_i,
  output logic [COEFF_W:0]   r_o
);

  localparam int EST_W = PROD_W + MU_W;

  logic [EST_W-1:0]  est;
  logic [COEFF_W:0]  qhat;
  logic [PROD_W-1:0] qm;

  assign est  = {{MU_W{1'b0}}, p_i} * {{PROD_W{1'b0}}, BARRETT_MU};
  assign qhat = (COEFF_W + 1)'(est >> BARRETT_SHIFT);
  // qhat*m never exceeds p_i, so the 46-bit product and difference cannot wrap.
  assign qm   = {{(PROD_W-COEFF_W-1){1'b0}}, qhat} * {{(PROD_W-COEFF_W){1'b0}}, m_i};
  assign r_o  = (COEFF_W + 1)'(p_i - qm);

endmodule

// File: rtl/dilithium_modmul.sv
// Three-stage pipelined (a*b) mod q multiplier with elastic valid/ready stages
// and a sideband tag plus operand range flag carried alongside each result.
module dilithium_modmul
  import dilithium_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [COEFF_W-1:0] a_i,
  input  logic [COEFF_W-1:0] b_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [COEFF_W-1:0] result_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               range_err_o
);

  // Handshake: a beat moves across a port only in a cycle where valid and
  // ready are both high; a stage loads when empty or when its content is
  // leaving in the same cycle, so bubbles collapse and full-rate flow holds.
  logic s1_v, s2_v, s3_v;
  logic s1_ld, s2_ld, s3_ld;

  logic [COEFF_W-1:0] s1_a, s1_b;
  logic [TAG_W-1:0]   s1_tag;
  logic               s1_err;

  logic [PROD_W-1:0]  s2_p;
  logic [TAG_W-1:0]   s2_tag;
  logic               s2_err;

  logic [COEFF_W-1:0] s3_r;
  logic [TAG_W-1:0]   s3_tag;
  logic               s3_err;

  logic [COEFF_W:0]   red_r;
  logic [COEFF_W-1:0] red_fin;

  assign s3_ld      = !s3_v || out_ready_i;
  assign s2_ld      = !s2_v || s3_ld;
  assign s1_ld      = !s1_v || s2_ld;
  assign in_ready_o = s1_ld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
      s1_err <= 1'b0;
    end else if (s1_ld) begin
      s1_v   <= in_valid_i;
      s1_a   <= a_i;
      s1_b   <= b_i;
      s1_tag <= tag_i;
      s1_err <= !(coeff_in_range(a_i) && coeff_in_range(b_i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_v   <= 1'b0;
      s2_p   <= '0;
      s2_tag <= '0;
      s2_err <= 1'b0;
    end else if (s2_ld) begin
      s2_v   <= s1_v;
      s2_p   <= {{(PROD_W-COEFF_W){1'b0}}, s1_a} * {{(PROD_W-COEFF_W){1'b0}}, s1_b};
      s2_tag <= s1_tag;
      s2_err <= s1_err;
    end
  end

  dilithium_reduction u_reduction (
    .p_i (s2_p),
    .m_i (Q),
    .r_o (red_r)
  );

  // Reducer output lies in [0, 2q); one subtraction lands it in [0, q).
  always_comb begin
    red_fin = red_r[COEFF_W-1:0];
    if (red_r >= {1'b0, Q}) begin
      red_fin = COEFF_W'(red_r - {1'b0, Q});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_v   <= 1'b0;
      s3_r   <= '0;
      s3_tag <= '0;
      s3_err <= 1'b0;
    end else if (s3_ld) begin
      s3_v   <= s2_v;
      s3_r   <= red_fin;
      s3_tag <= s2_tag;
      s3_err <= s2_err;
    end
  end

  // Stale data left behind after a drain is masked so idle outputs read 0.
  assign out_valid_o = s3_v;
  assign result_o    = s3_v ? s3_r   : '0;
  assign tag_o       = s3_v ? s3_tag : '0;
  assign range_err_o = s3_v && s3_err;

endmodule

// File: doc/dilithium_modmul.md
DILITHIUM_MODMUL -- requirements
Module: dilithium_modmul

Interface
REQ-001 Parameter: TAG_W, 8, width of the sideband tag carried with each operation.
REQ-002 Port: clk_i  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid_i  input  1  operand pair valid.
REQ-005 Port: in_ready_o  output  1  block can accept an operand pair this cycle.
REQ-006 Port: a_i  input  23  operand a, expected in [0, q-1], q = 8380417.
REQ-007 Port: b_i  input  23  operand b, expected in [0, q-1].
REQ-008 Port: tag_i  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-009 Port: out_valid_o  output  1  result valid.
REQ-010 Port: out_ready_i  input  1  downstream accepts the result.
REQ-011 Port: result_o  output  23  (a*b) mod q, always in [0, q-1].
REQ-012 Port: tag_o  output  TAG_W  tag of the operation on result_o.
REQ-013 Port: range_err_o  output  1  high with a result whose a_i or b_i was >= q.

Function
REQ-014 The block SHALL be a 3-stage pipeline: S1 registers a, b, tag; S2 registers the 46-bit product a*b; S3 registers the reduced value.
REQ-015 A transfer SHALL occur on a port only in a cycle where valid and ready are both high.
REQ-016 Each stage SHALL hold its own valid bit and load when it is empty or the next stage/output is consuming its content in the same cycle.
REQ-017 in_ready_o SHALL equal (S1 empty) OR (S1 advancing this cycle), combinationally.
REQ-018 With out_ready_i held high, latency SHALL be exactly 3 cycles from input handshake to out_valid_o, at one result per cycle.
REQ-019 Bubbles SHALL collapse: an empty stage is filled even while a later stage stalls.
REQ-020 While out_valid_o=1 and out_ready_i=0, result_o, tag_o and range_err_o SHALL hold stable, and nothing SHALL be dropped or duplicated.
REQ-021 Results SHALL leave in input order.
REQ-022 The S2 product SHALL be the full 46-bit unsigned product, with no truncation.
REQ-023 The S3 value SHALL be the 46-bit product passed through the shared reduction.
REQ-024 The S3 value SHALL then get one conditional subtraction of q so that the result is strictly less than q (a value equal to q maps to 0).
REQ-025 range_err_o SHALL be computed at S1.
REQ-026 range_err_o SHALL travel with the data.
REQ-027 Out-of-range operands SHALL still be processed and the result SHALL still be emitted.
REQ-028 On simultaneous input and output handshakes with the pipeline full, the block SHALL accept and emit in the same cycle, with no lost beat.

Reset
REQ-029 On rst_ni low, all stage valid bits SHALL clear immediately, asynchronously.
REQ-030 During reset, out_valid_o SHALL be 0, in_ready_o SHALL be 1, and result_o, tag_o and range_err_o SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all in-flight results.
REQ-032 No result SHALL appear until 3 cycles after the first handshake following deassertion.
REQ-033 Datapath registers MAY omit reset, provided outputs read 0 while out_valid_o is 0.

Structure
REQ-034 q (8380417), the 23-bit coefficient width and the 46-bit product width SHALL be constants in the shared dilithium package.
REQ-035 The block SHALL instantiate exactly one sub-module, dilithium_reduction (46-bit product to mod-q reducer), between S2 and S3, with m_i tied to the package q.
REQ-036 The final conditional subtraction SHALL live in dilithium_modmul.

Verification
REQ-037 Boundary values, a=q-1, b=q-1, tag=0x5A -> result 1, tag 0x5A, 3 cycles later, range_err_o=0.
REQ-038 Back-to-back stream, a=4194304, b=2, then a=0, b=1234567, then a=1, b=q-1, out_ready_i=1 -> results 8191, 0, 8380416 on consecutive cycles.
REQ-039 Backpressure: hold out_ready_i=0 for 5 cycles with 4 inputs offered -> in_ready_o drops after 3 accepted, outputs stay stable, and on release all 4 emerge in order.
REQ-040 Out-of-range operand, a=8380417, b=5 -> result 0, range_err_o=1.
REQ-041 Reset mid-operation: assert rst_ni low with 2 results in flight -> out_valid_o=0 immediately and no stale result after release.
REQ-042 Random scoreboard: 10k random in-range operands with random valid/ready toggling -> every result matches a*b mod q, in order.
